// File: rtl/jtdd_char_romrq_if.sv
// SDRAM read port seen by the character ROM requester.
// The requester holds a level request until the acknowledge pulse, then waits for the data pulse.
interface jtdd_char_romrq_if;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_din;

    modport master (
        output sdram_addr,
        output sdram_req,
        input  sdram_ack,
        input  sdram_rdy,
        input  sdram_din
    );

    modport slave (
        input  sdram_addr,
        input  sdram_req,
        output sdram_ack,
        output sdram_rdy,
        output sdram_din
    );
endinterface

// File: rtl/jtdd_char_romrq.sv
// Single-entry word cache between the character layer and the SDRAM.
// A miss fetches one 16-bit word; the byte lane is picked by addr[0].
module jtdd_char_romrq #(
    parameter logic [21:0] BASE = 22'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [14:0]                addr,
    input  logic                       addr_ok,
    input  logic                       flush,
    output logic [7:0]                 data,
    output logic                       data_ok,
    jtdd_char_romrq_if.master          sdram
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [13:0] tag;
        logic [15:0] word;
    } entry_t;

    state_t      state, state_n;
    entry_t      ent, ent_n;
    logic [13:0] ptag, ptag_n;
    logic        cancel, cancel_n;
    logic        req, req_n;
    logic [21:0] saddr, saddr_n;
    logic        hit;
    logic        fill;

    assign hit     = addr_ok & ent.valid & (addr[14:1] == ent.tag);
    assign data_ok = hit;
    assign data    = addr[0] ? ent.word[15:8] : ent.word[7:0];

    assign sdram.sdram_req  = req;
    assign sdram.sdram_addr = saddr;

    always_comb begin
        state_n  = state;
        ent_n    = ent;
        ptag_n   = ptag;
        cancel_n = cancel;
        req_n    = req;
        saddr_n  = saddr;
        fill     = 1'b0;
        case (state)
            IDLE: begin
                cancel_n = 1'b0;
                if (!flush && addr_ok && !hit) begin
                    ptag_n  = addr[14:1];
                    saddr_n = BASE + {8'b0, addr[14:1]};
                    req_n   = 1'b1;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram.sdram_ack) begin
                    req_n = 1'b0;
                    // Data arriving with the ack counts as the completion.
                    if (sdram.sdram_rdy) fill = 1'b1;
                    else                 state_n = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (sdram.sdram_rdy) fill = 1'b1;
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase

        if (fill) begin
            if (!cancel && !flush) begin
                ent_n.word  = sdram.sdram_din;
                ent_n.tag   = ptag;
                ent_n.valid = 1'b1;
            end
            cancel_n = 1'b0;
            state_n  = IDLE;
        end

        // A flush during a fetch marks the in-flight word as stale.
        if (flush) begin
            ent_n.valid = 1'b0;
            if (state_n != IDLE) cancel_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ent    <= '0;
            ptag   <= '0;
            cancel <= 1'b0;
            req    <= 1'b0;
            saddr  <= '0;
        end else begin
            state  <= state_n;
            ent    <= ent_n;
            ptag   <= ptag_n;
            cancel <= cancel_n;
            req    <= req_n;
            saddr  <= saddr_n;
        end
    end
endmodule

// File: tb/tb_jtdd_char_romrq.sv
// Directed bench for the character ROM requester with hand-computed expectations.
module tb_jtdd_char_romrq;
    localparam logic [21:0] BASE = 22'h10000;

    logic        clk;
    logic        rst_n;
    logic [14:0] addr;
    logic        addr_ok;
    logic        flush;
    logic [7:0]  data;
    logic        data_ok;

    int errors = 0;
    int checks = 0;

    jtdd_char_romrq_if sdram ();

    jtdd_char_romrq #(.BASE(BASE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .addr_ok (addr_ok),
        .flush   (flush),
        .data    (data),
        .data_ok (data_ok),
        .sdram   (sdram.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        addr    = '0;
        addr_ok = 1'b0;
        flush   = 1'b0;
        sdram.sdram_ack = 1'b0;
        sdram.sdram_rdy = 1'b0;
        sdram.sdram_din = '0;
        step();
        step();
        chk("rst_req",     {31'b0, sdram.sdram_req}, 32'd0);
        chk("rst_saddr",   {10'b0, sdram.sdram_addr}, 32'd0);
        chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
        chk("rst_data",    {24'b0, data}, 32'd0);
        rst_n = 1'b1;
        step();

        // Cold miss, ack after two cycles, data three cycles after ack
        addr = 15'h0003; addr_ok = 1'b1;
        #1 chk("cold_miss_dok", {31'b0, data_ok}, 32'd0);
        step();
        chk("cold_req",   {31'b0, sdram.sdram_req}, 32'd1);
        chk("cold_saddr", {10'b0, sdram.sdram_addr}, 32'h10001);
        step();
        chk("cold_req_hold", {31'b0, sdram.sdram_req}, 32'd1);
        sdram.sdram_ack = 1'b1;
        step();
        sdram.sdram_ack = 1'b0;
        chk("cold_req_drop", {31'b0, sdram.sdram_req}, 32'd0);
        step();
        step();
        sdram.sdram_din = 16'hA55A; sdram.sdram_rdy = 1'b1;
        step();
        sdram.sdram_rdy = 1'b0;
        chk("cold_dok",  {31'b0, data_ok}, 32'd1);
        chk("cold_data", {24'b0, data}, 32'hA5);

        // Hit on the other byte of the cached word
        addr = 15'h0002;
        #1;
        chk("hit_dok",  {31'b0, data_ok}, 32'd1);
        chk("hit_data", {24'b0, data}, 32'h5A);
        step();
        chk("hit_noreq", {31'b0, sdram.sdram_req}, 32'd0);

        // Ack and data in the same cycle
        addr = 15'h0010;
        step();
        chk("ar_req",   {31'b0, sdram.sdram_req}, 32'd1);
        chk("ar_saddr", {10'b0, sdram.sdram_addr}, 32'h10008);
        sdram.sdram_ack = 1'b1; sdram.sdram_rdy = 1'b1; sdram.sdram_din = 16'h1234;
        step();
        sdram.sdram_ack = 1'b0; sdram.sdram_rdy = 1'b0;
        chk("ar_req_drop", {31'b0, sdram.sdram_req}, 32'd0);
        chk("ar_dok",      {31'b0, data_ok}, 32'd1);
        chk("ar_data",     {24'b0, data}, 32'h34);

        // Flush in IDLE: invalidates and blocks the request that cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fi_dok",     {31'b0, data_ok}, 32'd0);
        chk("fi_blocked", {31'b0, sdram.sdram_req}, 32'd0);
        step();
        chk("fi_refetch", {31'b0, sdram.sdram_req}, 32'd1);

        // Flush while waiting for data: returning word discarded
        sdram.sdram_ack = 1'b1;
        step();
        sdram.sdram_ack = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        sdram.sdram_rdy = 1'b1; sdram.sdram_din = 16'hFFFF;
        step();
        sdram.sdram_rdy = 1'b0;
        chk("fm_dok", {31'b0, data_ok}, 32'd0);
        chk("fm_req", {31'b0, sdram.sdram_req}, 32'd0);
        step();
        chk("fm_rereq",   {31'b0, sdram.sdram_req}, 32'd1);
        chk("fm_resaddr", {10'b0, sdram.sdram_addr}, 32'h10008);
        sdram.sdram_ack = 1'b1; sdram.sdram_rdy = 1'b1; sdram.sdram_din = 16'hBEEF;
        step();
        sdram.sdram_ack = 1'b0; sdram.sdram_rdy = 1'b0;
        chk("fm_fill_dok",  {31'b0, data_ok}, 32'd1);
        chk("fm_fill_data", {24'b0, data}, 32'hEF);

        // Address change while waiting for ack: fill uses the latched tag
        addr = 15'h0004;
        step();
        chk("ac_saddr", {10'b0, sdram.sdram_addr}, 32'h10002);
        addr = 15'h0100;
        sdram.sdram_ack = 1'b1;
        step();
        sdram.sdram_ack = 1'b0;
        sdram.sdram_rdy = 1'b1; sdram.sdram_din = 16'hCAFE;
        step();
        sdram.sdram_rdy = 1'b0;
        chk("ac_newaddr_miss", {31'b0, data_ok}, 32'd0);
        addr = 15'h0005;
        #1;
        chk("ac_oldtag_dok",  {31'b0, data_ok}, 32'd1);
        chk("ac_oldtag_data", {24'b0, data}, 32'hCA);
        addr = 15'h0100;
        step();
        chk("ac_req2",   {31'b0, sdram.sdram_req}, 32'd1);
        chk("ac_saddr2", {10'b0, sdram.sdram_addr}, 32'h10080);

        // Reset while waiting for data; late rdy afterwards is ignored
        sdram.sdram_ack = 1'b1;
        step();
        sdram.sdram_ack = 1'b0;
        rst_n = 1'b0; addr_ok = 1'b0;
        #1;
        chk("mr_req",   {31'b0, sdram.sdram_req}, 32'd0);
        chk("mr_saddr", {10'b0, sdram.sdram_addr}, 32'd0);
        chk("mr_dok",   {31'b0, data_ok}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        sdram.sdram_rdy = 1'b1; sdram.sdram_ack = 1'b1; sdram.sdram_din = 16'h1111;
        step();
        sdram.sdram_rdy = 1'b0; sdram.sdram_ack = 1'b0;
        chk("mr_late_req", {31'b0, sdram.sdram_req}, 32'd0);
        addr_ok = 1'b1;
        #1;
        chk("mr_nofill_dok", {31'b0, data_ok}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jtdd_char_romrq.md
JTDD_CHAR_ROMRQ -- requirements
Module: jtdd_char_romrq

Interface
REQ-001 Parameter BASE, default 22'h0, SDRAM word offset of the character ROM region.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 addr  in  15  byte address from the character layer.
REQ-005 addr_ok  in  1  request valid; addr is meaningful while high.
REQ-006 flush  in  1  invalidate cached word (ROM download or bank change).
REQ-007 data  out  8  byte returned to the layer.
REQ-008 data_ok  out  1  data valid for the current addr.
REQ-009 sdram_addr  out  22  SDRAM 16-bit word address.
REQ-010 sdram_req  out  1  read request, level, held until acknowledged.
REQ-011 sdram_ack  in  1  one-cycle pulse: request accepted.
REQ-012 sdram_rdy  in  1  one-cycle pulse: sdram_din valid.
REQ-013 sdram_din  in  16  read word, low byte = even address.

Function
REQ-014 Block SHALL keep one cache entry: valid bit, 14-bit tag, 16-bit word.
REQ-015 hit SHALL be addr_ok AND valid AND (addr[14:1] == tag), combinational.
REQ-016 data_ok SHALL equal hit combinationally; data SHALL be word[15:8] when addr[0]=1, else word[7:0].
REQ-017 data SHALL be don't-care when data_ok=0; bench checks data only when data_ok=1.
REQ-018 FSM states: IDLE, WAIT_ACK, WAIT_DATA.
REQ-019 IDLE: addr_ok=1, hit=0, flush=0 -> latch ptag=addr[14:1], sdram_addr = BASE + {8'b0, addr[14:1]} (22-bit sum, wraps modulo 2^22), sdram_req=1, go WAIT_ACK.
REQ-020 WAIT_ACK: sdram_req held 1, sdram_addr stable; sdram_ack=1 -> sdram_req=0, go WAIT_DATA.
REQ-021 WAIT_ACK with sdram_ack=1 and sdram_rdy=1 in the same cycle -> treated as completion: store word, go IDLE.
REQ-022 WAIT_DATA: sdram_rdy=1 -> word=sdram_din, tag=ptag, valid=1 (unless cancelled), go IDLE.
REQ-023 Miss-to-data_ok latency: 3 cycles min (req, ack, rdy, then hit in IDLE cycle after rdy) with zero-wait SDRAM; addr held constant throughout.
REQ-024 addr change during fetch: fetch SHALL complete and fill with ptag; IDLE then re-evaluates, new miss starts a new fetch; no request aborted on the SDRAM side.
REQ-025 addr_ok low during fetch: fetch SHALL still complete and fill.
REQ-026 flush=1: valid SHALL clear next edge; if asserted in WAIT_ACK/WAIT_DATA a cancel flag SHALL be set so the returning word is discarded (valid stays 0); cancel cleared on return to IDLE.
REQ-027 flush=1 in IDLE SHALL block new requests that cycle.
REQ-028 sdram_rdy or sdram_ack in IDLE SHALL be ignored.
REQ-029 At most one outstanding SDRAM request at any time.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state=IDLE, sdram_req=0, sdram_addr=0, valid=0, cancel=0, tag=0, word=0, ptag=0; hence data_ok=0, data=0.
REQ-031 Reset mid-fetch SHALL drop the request; a late sdram_rdy after release lands in IDLE and is ignored.

Verification
REQ-032 Cold miss: BASE=22'h10000, addr=15'h0003, addr_ok=1, ack 2 cycles later, rdy with 16'hA55A 3 cycles after ack -> sdram_addr=22'h10001, sdram_req high until ack, then data_ok=1, data=8'hA5.
REQ-033 Hit: after REQ-032, addr=15'h0002 -> data_ok=1 same cycle, data=8'h5A, no sdram_req.
REQ-034 Same-cycle ack+rdy: miss addr=15'h0010, ack and rdy together with 16'h1234 -> IDLE next cycle, data_ok=1, data=8'h34.
REQ-035 Flush mid-fetch: flush pulse in WAIT_DATA, rdy with 16'hFFFF -> valid=0, data_ok=0, new request issued for the same addr.
REQ-036 Addr change mid-fetch: addr 15'h0004 -> 15'h0100 in WAIT_ACK -> first fill tag=14'h0002, then second request sdram_addr=BASE+22'h80.
REQ-037 Reset in WAIT_DATA, then rdy pulse after release -> sdram_req=0, data_ok=0, state IDLE, no fill.
